// File: rtl/axi_divide_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | axi_divide_pkg                                                   |
// | State encoding and status-flag indices shared by the divider.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package axi_divide_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PREP = 3'd1;
  localparam logic [2:0] ST_CALC = 3'd2;
  localparam logic [2:0] ST_FIX  = 3'd3;
  localparam logic [2:0] ST_OUT  = 3'd4;

  localparam int FLAG_OVERFLOW = 0;
  localparam int FLAG_DIV0     = 1;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    PREP = ST_PREP,
    CALC = ST_CALC,
    FIX  = ST_FIX,
    OUT  = ST_OUT
  } state_e;

endpackage
`default_nettype wire

// File: rtl/divide_core_iter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | divide_core_iter                                                 |
// | Unsigned restoring divider core, one quotient bit per cycle.     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module divide_core_iter #(
  parameter int WIDTH_N = 16,
  parameter int WIDTH_D = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               abort_i,
  input  logic               start_i,
  input  logic [WIDTH_N-1:0] dividend_i,
  input  logic [WIDTH_D-1:0] divisor_i,
  output logic               last_o,
  output logic [WIDTH_N-1:0] quotient_o,
  output logic [WIDTH_D-1:0] remainder_o
);

  localparam int               CNT_W = $clog2(WIDTH_N + 1);
  localparam logic [CNT_W-1:0] ITERS = CNT_W'(WIDTH_N);

  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH_N-1:0] acc_q, acc_d;
  logic [WIDTH_D-1:0] rem_q, rem_d;
  logic [WIDTH_D-1:0] div_q;
  logic [WIDTH_D:0]   rem_sh;
  logic [WIDTH_D:0]   trial;

  // acc_q shifts dividend bits out of the top while quotient bits enter at the bottom
  always_comb begin
    rem_sh = {rem_q, acc_q[WIDTH_N-1]};
    trial  = rem_sh - {1'b0, div_q};
    rem_d  = trial[WIDTH_D] ? rem_sh[WIDTH_D-1:0] : trial[WIDTH_D-1:0];
    acc_d  = {acc_q[WIDTH_N-2:0], ~trial[WIDTH_D]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      acc_q <= '0;
      rem_q <= '0;
      div_q <= '0;
    end else if (abort_i) begin
      cnt_q <= '0;
    end else if (start_i) begin
      cnt_q <= ITERS;
      acc_q <= dividend_i;
      rem_q <= '0;
      div_q <= divisor_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
      acc_q <= acc_d;
      rem_q <= rem_d;
    end
  end

  assign last_o      = (cnt_q == CNT_W'(1));
  assign quotient_o  = acc_q;
  assign remainder_o = rem_q;

endmodule
`default_nettype wire

// File: rtl/axi_divide.sv
`default_nettype none
// +------------------------------------------------------------------+
// | axi_divide                                                       |
// | AXI-Stream joined divider: quotient, remainder and status flags. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module axi_divide
  import axi_divide_pkg::*;
#(
  parameter int WIDTH_N = 16,
  parameter int WIDTH_D = 16,
  parameter int SIGNED  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic [WIDTH_N-1:0] n_tdata,
  input  logic               n_tlast,
  input  logic               n_tvalid,
  output logic               n_tready,
  input  logic [WIDTH_D-1:0] d_tdata,
  input  logic               d_tlast,
  input  logic               d_tvalid,
  output logic               d_tready,
  output logic [WIDTH_N-1:0] q_tdata,
  output logic [WIDTH_D-1:0] r_tdata,
  output logic [1:0]         q_tuser,
  output logic               q_tlast,
  output logic               q_tvalid,
  input  logic               q_tready
);

  localparam bit                 IS_SIGNED = (SIGNED != 0);
  localparam logic [WIDTH_N-1:0] N_MAX     = {1'b0, {(WIDTH_N-1){1'b1}}};
  localparam logic [WIDTH_N-1:0] N_MIN     = {1'b1, {(WIDTH_N-1){1'b0}}};

  state_e             state_q;
  logic [WIDTH_N-1:0] n_q;
  logic [WIDTH_D-1:0] d_q;
  logic               last_q;
  logic               n_neg_q, q_neg_q, div0_q, ovf_q;
  logic [WIDTH_N-1:0] q_tdata_q, q_res_d;
  logic [WIDTH_D-1:0] r_tdata_q, r_res_d;
  logic [1:0]         q_tuser_q;
  logic               q_tlast_q, q_tvalid_q;

  logic               is_idle, accept;
  logic               n_neg, d_neg;
  logic [WIDTH_N-1:0] mag_n, quo;
  logic [WIDTH_D-1:0] mag_d, rem;
  logic               core_last;
  logic               unused_d_tlast;

  assign unused_d_tlast = d_tlast;

  assign is_idle  = (state_q == IDLE);
  assign accept   = is_idle & n_tvalid & d_tvalid;
  assign n_tready = is_idle & d_tvalid & ~reset;
  assign d_tready = is_idle & n_tvalid & ~reset;

  assign n_neg = IS_SIGNED & n_q[WIDTH_N-1];
  assign d_neg = IS_SIGNED & d_q[WIDTH_D-1];
  assign mag_n = n_neg ? -n_q : n_q;
  assign mag_d = d_neg ? -d_q : d_q;

  divide_core_iter #(
    .WIDTH_N(WIDTH_N),
    .WIDTH_D(WIDTH_D)
  ) u_core (
    .clk        (clk),
    .reset      (reset),
    .abort_i    (clear),
    .start_i    (state_q == PREP),
    .dividend_i (mag_n),
    .divisor_i  (mag_d),
    .last_o     (core_last),
    .quotient_o (quo),
    .remainder_o(rem)
  );

  // Remainder follows the dividend sign so that n = q*d + r holds
  always_comb begin
    q_res_d = q_neg_q ? -quo : quo;
    r_res_d = n_neg_q ? -rem : rem;
    if (div0_q) begin
      r_res_d = '0;
      if (!IS_SIGNED)   q_res_d = '1;
      else if (n_neg_q) q_res_d = N_MIN;
      else              q_res_d = N_MAX;
    end else if (ovf_q) begin
      q_res_d = N_MAX;
      r_res_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      n_q        <= '0;
      d_q        <= '0;
      last_q     <= 1'b0;
      n_neg_q    <= 1'b0;
      q_neg_q    <= 1'b0;
      div0_q     <= 1'b0;
      ovf_q      <= 1'b0;
      q_tdata_q  <= '0;
      r_tdata_q  <= '0;
      q_tuser_q  <= '0;
      q_tlast_q  <= 1'b0;
      q_tvalid_q <= 1'b0;
    end else if (clear) begin
      state_q    <= IDLE;
      q_tdata_q  <= '0;
      r_tdata_q  <= '0;
      q_tuser_q  <= '0;
      q_tlast_q  <= 1'b0;
      q_tvalid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            n_q     <= n_tdata;
            d_q     <= d_tdata;
            last_q  <= n_tlast;
            state_q <= PREP;
          end
        end
        PREP: begin
          n_neg_q <= n_neg;
          q_neg_q <= n_neg ^ d_neg;
          div0_q  <= (d_q == '0);
          ovf_q   <= IS_SIGNED && (n_q == N_MIN) && (d_q == '1);
          state_q <= CALC;
        end
        CALC: begin
          if (core_last) state_q <= FIX;
        end
        FIX: begin
          q_tdata_q                <= q_res_d;
          r_tdata_q                <= r_res_d;
          q_tuser_q[FLAG_DIV0]     <= div0_q;
          q_tuser_q[FLAG_OVERFLOW] <= ovf_q & ~div0_q;
          q_tlast_q                <= last_q;
          q_tvalid_q               <= 1'b1;
          state_q                  <= OUT;
        end
        OUT: begin
          if (q_tready) begin
            q_tvalid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign q_tdata  = q_tdata_q;
  assign r_tdata  = r_tdata_q;
  assign q_tuser  = q_tuser_q;
  assign q_tlast  = q_tlast_q;
  assign q_tvalid = q_tvalid_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_divide.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_axi_divide                                                    |
// | Directed bench: signed and unsigned dividers driven in lockstep. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_axi_divide;

  logic        clk = 1'b0;
  logic        reset, clear;
  logic [15:0] n_tdata, d_tdata;
  logic        n_tlast, n_tvalid, d_tlast, d_tvalid, q_tready;

  logic        s_n_tready, s_d_tready, s_q_tlast, s_q_tvalid;
  logic [15:0] s_q_tdata, s_r_tdata;
  logic [1:0]  s_q_tuser;
  logic        u_n_tready, u_d_tready, u_q_tlast, u_q_tvalid;
  logic [15:0] u_q_tdata, u_r_tdata;
  logic [1:0]  u_q_tuser;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axi_divide #(.WIDTH_N(16), .WIDTH_D(16), .SIGNED(1)) u_s (
    .clk(clk), .reset(reset), .clear(clear),
    .n_tdata(n_tdata), .n_tlast(n_tlast), .n_tvalid(n_tvalid), .n_tready(s_n_tready),
    .d_tdata(d_tdata), .d_tlast(d_tlast), .d_tvalid(d_tvalid), .d_tready(s_d_tready),
    .q_tdata(s_q_tdata), .r_tdata(s_r_tdata), .q_tuser(s_q_tuser),
    .q_tlast(s_q_tlast), .q_tvalid(s_q_tvalid), .q_tready(q_tready)
  );

  axi_divide #(.WIDTH_N(16), .WIDTH_D(16), .SIGNED(0)) u_u (
    .clk(clk), .reset(reset), .clear(clear),
    .n_tdata(n_tdata), .n_tlast(n_tlast), .n_tvalid(n_tvalid), .n_tready(u_n_tready),
    .d_tdata(d_tdata), .d_tlast(d_tlast), .d_tvalid(d_tvalid), .d_tready(u_d_tready),
    .q_tdata(u_q_tdata), .r_tdata(u_r_tdata), .q_tuser(u_q_tuser),
    .q_tlast(u_q_tlast), .q_tvalid(u_q_tvalid), .q_tready(q_tready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic accept_op(input logic [15:0] n, input logic [15:0] d, input logic last);
    int guard;
    @(negedge clk);
    n_tdata = n; d_tdata = d; n_tlast = last; n_tvalid = 1'b1; d_tvalid = 1'b1;
    #1;
    guard = 0;
    while (!(s_n_tready && s_d_tready && u_n_tready) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("accept_ready", 64'({s_n_tready, s_d_tready, u_n_tready, u_d_tready}), 64'hF);
    @(posedge clk);
    #1;
    n_tvalid = 1'b0; d_tvalid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!(s_q_tvalid && u_q_tvalid) && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic expect_out(input string tag,
                            input logic [15:0] qs, input logic [15:0] rs, input logic [1:0] us,
                            input logic [15:0] qu, input logic [15:0] ru, input logic [1:0] uu,
                            input logic last);
    check({tag, "_s"}, 64'({s_q_tvalid, s_q_tlast, s_q_tuser, s_q_tdata, s_r_tdata}),
          64'({1'b1, last, us, qs, rs}));
    check({tag, "_u"}, 64'({u_q_tvalid, u_q_tlast, u_q_tuser, u_q_tdata, u_r_tdata}),
          64'({1'b1, last, uu, qu, ru}));
  endtask

  task automatic release_out(input int delay);
    repeat (delay) @(negedge clk);
    @(negedge clk);
    q_tready = 1'b1;
    @(posedge clk);
    #1;
    q_tready = 1'b0;
    check("released", 64'({s_q_tvalid, u_q_tvalid}), 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [15:0] n, input logic [15:0] d, input logic last,
                        input logic [15:0] qs, input logic [15:0] rs, input logic [1:0] us,
                        input logic [15:0] qu, input logic [15:0] ru, input logic [1:0] uu,
                        input int delay);
    int cyc;
    accept_op(n, d, last);
    wait_valid(cyc);
    check({tag, "_lat"}, 64'(cyc), 64'd18);
    expect_out(tag, qs, rs, us, qu, ru, uu, last);
    release_out(delay);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc, viol, sn, sd, tq, tr;
    logic [15:0] rn, rd, eqs, ers, equ, eru;
    logic [1:0]  eus, euu;

    reset = 1'b1; clear = 1'b0; q_tready = 1'b0;
    n_tdata = 16'd3; d_tdata = 16'd1; n_tlast = 1'b0; d_tlast = 1'b0;
    n_tvalid = 1'b1; d_tvalid = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'({s_n_tready, s_d_tready, u_n_tready, u_d_tready}), 64'd0);
    check("rst_out_s", 64'({s_q_tvalid, s_q_tlast, s_q_tuser, s_q_tdata, s_r_tdata}), 64'd0);
    check("rst_out_u", 64'({u_q_tvalid, u_q_tlast, u_q_tuser, u_q_tdata, u_r_tdata}), 64'd0);
    n_tvalid = 1'b0; d_tvalid = 1'b0;
    reset = 1'b0;

    run_op("u100_7",  16'd100,   16'd7,     1'b1, 16'd14,   16'd2,    2'b00, 16'd14,   16'd2,    2'b00, 0);
    run_op("n7_2",    16'hFFF9,  16'd2,     1'b0, 16'hFFFD, 16'hFFFF, 2'b00, 16'h7FFC, 16'd1,    2'b00, 0);
    run_op("p7_n2",   16'd7,     16'hFFFE,  1'b1, 16'hFFFD, 16'd1,    2'b00, 16'd0,    16'd7,    2'b00, 0);
    run_op("min_m1",  16'h8000,  16'hFFFF,  1'b0, 16'h7FFF, 16'd0,    2'b01, 16'd0,    16'h8000, 2'b00, 0);
    run_op("p500_0",  16'd500,   16'd0,     1'b1, 16'h7FFF, 16'd0,    2'b10, 16'hFFFF, 16'd0,    2'b10, 0);
    run_op("n5_0",    16'hFFFB,  16'd0,     1'b0, 16'h8000, 16'd0,    2'b10, 16'hFFFF, 16'd0,    2'b10, 0);
    run_op("p1000_n3",16'd1000,  16'hFFFD,  1'b1, 16'hFEB3, 16'd1,    2'b00, 16'd0,    16'd1000, 2'b00, 0);
    run_op("n30000_7",16'h8AD0,  16'd7,     1'b0, 16'hEF43, 16'hFFFB, 2'b00, 16'h13D4, 16'd4,    2'b00, 0);

    // A lone valid on either stream must never be consumed
    @(negedge clk);
    n_tdata = 16'd9; n_tvalid = 1'b1; d_tvalid = 1'b0;
    viol = 0;
    repeat (10) begin
      @(negedge clk);
      if (s_n_tready || u_n_tready || !s_d_tready || !u_d_tready || s_q_tvalid) viol++;
    end
    n_tvalid = 1'b0; d_tvalid = 1'b1; d_tdata = 16'd4;
    repeat (10) begin
      @(negedge clk);
      if (s_d_tready || u_d_tready || !s_n_tready || !u_n_tready || s_q_tvalid) viol++;
    end
    d_tvalid = 1'b0;
    check("lone_valid", 64'(viol), 64'd0);
    run_op("after_lone", 16'd45, 16'd6, 1'b1, 16'd7, 16'd3, 2'b00, 16'd7, 16'd3, 2'b00, 0);

    // Back-pressure with the next operands already waiting
    accept_op(16'd1000, 16'd7, 1'b1);
    wait_valid(cyc);
    check("bp_lat", 64'(cyc), 64'd18);
    @(negedge clk);
    n_tdata = 16'd300; d_tdata = 16'd5; n_tlast = 1'b0; n_tvalid = 1'b1; d_tvalid = 1'b1;
    viol = 0;
    repeat (20) begin
      @(negedge clk);
      if ({s_q_tvalid, s_q_tlast, s_q_tuser, s_q_tdata, s_r_tdata} !== {1'b1, 1'b1, 2'b00, 16'd142, 16'd6} ||
          s_n_tready || u_n_tready || s_d_tready)
        viol++;
    end
    check("bp_hold", 64'(viol), 64'd0);
    q_tready = 1'b1;
    @(posedge clk);
    #1;
    q_tready = 1'b0;
    check("bp_next_ready", 64'({s_n_tready, s_d_tready, s_q_tvalid}), 64'b110);
    @(posedge clk);
    #1;
    n_tvalid = 1'b0; d_tvalid = 1'b0;
    wait_valid(cyc);
    check("bp2_lat", 64'(cyc), 64'd18);
    expect_out("bp2", 16'd60, 16'd0, 2'b00, 16'd60, 16'd0, 2'b00, 1'b0);
    release_out(0);

    // clear in CALC drops the operation and zeroes the outputs
    accept_op(16'd1234, 16'd10, 1'b1);
    repeat (5) @(posedge clk);
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    viol = 0;
    repeat (30) begin
      @(negedge clk);
      if (s_q_tvalid || u_q_tvalid) viol++;
    end
    check("clr_calc_noout", 64'(viol), 64'd0);
    check("clr_vals_s", 64'({s_q_tvalid, s_q_tlast, s_q_tuser, s_q_tdata, s_r_tdata}), 64'd0);

    // clear coinciding with the join handshake
    run_op("pre_clr", 16'd81, 16'd9, 1'b1, 16'd9, 16'd0, 2'b00, 16'd9, 16'd0, 2'b00, 0);
    @(negedge clk);
    n_tdata = 16'd50; d_tdata = 16'd5; n_tvalid = 1'b1; d_tvalid = 1'b1; clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0; n_tvalid = 1'b0; d_tvalid = 1'b0;
    viol = 0;
    repeat (25) begin
      @(negedge clk);
      if (s_q_tvalid || u_q_tvalid) viol++;
    end
    check("clr_join_noout", 64'(viol), 64'd0);
    check("clr_join_vals_u", 64'({u_q_tvalid, u_q_tlast, u_q_tuser, u_q_tdata, u_r_tdata}), 64'd0);

    // Asynchronous reset while the result is waiting in OUT
    accept_op(16'd77, 16'd5, 1'b1);
    wait_valid(cyc);
    check("arst_pre_valid", 64'({s_q_tvalid, u_q_tvalid}), 64'b11);
    #2;
    reset = 1'b1;
    #1;
    check("arst_out_s", 64'({s_q_tvalid, s_q_tlast, s_q_tuser, s_q_tdata, s_r_tdata}), 64'd0);
    check("arst_out_u", 64'({u_q_tvalid, u_q_tlast, u_q_tuser, u_q_tdata, u_r_tdata}), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    viol = 0;
    repeat (25) begin
      @(negedge clk);
      if (s_q_tvalid || u_q_tvalid) viol++;
    end
    check("arst_noout", 64'(viol), 64'd0);
    run_op("after_arst", 16'd77, 16'd5, 1'b0, 16'd15, 16'd2, 2'b00, 16'd15, 16'd2, 2'b00, 0);

    // Randomised operands against a C-semantics model, with throttled valid/ready
    for (int i = 0; i < 40; i++) begin
      rn = 16'($urandom);
      rd = (i % 4 == 0) ? 16'($urandom_range(1, 9)) : 16'($urandom);
      if (i == 13) rd = 16'd0;
      if (i == 21) begin rn = 16'h8000; rd = 16'hFFFF; end
      sn = int'($signed(rn));
      sd = int'($signed(rd));
      if (sd == 0) begin
        eqs = (sn < 0) ? 16'h8000 : 16'h7FFF; ers = 16'd0; eus = 2'b10;
      end else if (sn == -32768 && sd == -1) begin
        eqs = 16'h7FFF; ers = 16'd0; eus = 2'b01;
      end else begin
        tq = sn / sd; tr = sn % sd;
        eqs = tq[15:0]; ers = tr[15:0]; eus = 2'b00;
      end
      if (rd == 16'd0) begin
        equ = 16'hFFFF; eru = 16'd0; euu = 2'b10;
      end else begin
        equ = rn / rd; eru = rn % rd; euu = 2'b00;
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_op($sformatf("rnd%0d", i), rn, rd, (i % 3 == 1), eqs, ers, eus, equ, eru, euu,
             int'($urandom_range(0, 4)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_divide.md
# axi_divide

AXI-Stream integer divider: joins a dividend stream and a divisor stream, then emits quotient, remainder and status flags on one output stream. It is the inverse-operation companion to the streaming multiplier in the RFNoC arithmetic library, used for gain normalisation and scale-factor computation. It uses an iterative restoring algorithm, one quotient bit per cycle, with one operation in flight, so it trades throughput for area and needs no DSP.

## Interface
- WIDTH_N, 16: dividend and quotient width.
- WIDTH_D, 16: divisor and remainder width; must be ≤ WIDTH_N.
- SIGNED, 1: 1 means two's-complement operands; 0 means unsigned.
- clk  in  1  clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous abort; returns to IDLE and drops any in-flight result.
- n_tdata  in  WIDTH_N  dividend.
- n_tlast, n_tvalid  in  1 each  dividend stream last and valid.
- n_tready  out  1  dividend stream ready.
- d_tdata  in  WIDTH_D  divisor.
- d_tlast  in  1  ignored.
- d_tvalid  in  1  divisor stream valid.
- d_tready  out  1  divisor stream ready.
- q_tdata  out  WIDTH_N  quotient.
- r_tdata  out  WIDTH_D  remainder.
- q_tuser  out  2  flags: [1] div_by_zero, [0] overflow.
- q_tlast, q_tvalid  out  1 each  output stream last and valid.
- q_tready  in  1  output stream ready.

## Operation
- Join: n_tready = IDLE & d_tvalid; d_tready = IDLE & n_tvalid.
  - Both inputs are consumed in the same cycle or neither is.
  - A lone valid input is never consumed.
- The FSM states and transitions are:
  - IDLE: on a join handshake, latch operands and n_tlast, then go to PREP.
  - PREP: take magnitudes (when SIGNED), record the result signs, detect zero divisor and the MIN/−1 case. Always 1 cycle.
  - CALC: WIDTH_N iterations. Each iteration shifts the partial remainder left by one, pulls in the next dividend bit, trial-subtracts |d|, and sets the quotient bit if the result is non-negative.
  - FIX: apply signs and the special-case overrides, and load the output register. Always 1 cycle.
  - OUT: hold q_tvalid = 1 with stable data until q_tready is high, then go to IDLE.
- Arithmetic:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend, so n = q·d + r and |r| < |d|.
- Divide by zero (d = 0): set q_tuser[1] and r = 0. The quotient is:
  - unsigned: all ones.
  - signed, n ≥ 0: most positive value.
  - signed, n < 0: most negative value.
- Overflow (SIGNED, n = most negative, d = −1): set q_tuser[0], q = most positive value, r = 0.
- CALC still runs its full count in both special cases, so latency is data-independent.
- q_tlast carries the latched n_tlast.

## Timing
- Reset and clear values:
  - State = IDLE.
  - n_tready, d_tready, q_tvalid, q_tlast = 0.
  - q_tdata, r_tdata, q_tuser = 0.
- Latency: join handshake in cycle T puts q_tvalid high in cycle T + WIDTH_N + 2 (PREP, then WIDTH_N CALC cycles, then FIX).
- Throughput: with q_tready held high, the minimum input spacing is WIDTH_N + 4 cycles (OUT lasts 1 cycle, then IDLE accepts on the next cycle).
- Back-pressure: q_tdata, r_tdata, q_tuser and q_tlast are stable while q_tvalid & !q_tready. No input is accepted before the OUT handshake completes.
- clear behaviour:
  - clear has priority over every transition.
  - Asserted in the same cycle as a join handshake: the operands are discarded and no result is produced.
  - Asserted during OUT: q_tvalid drops the next cycle.
- An asynchronous reset asserted mid-operation forces the reset values immediately, and no result is produced. After reset deasserts, the first accept happens no earlier than the first clk edge.
- The iteration counter is $clog2(WIDTH_N+1) bits and does not wrap.

## Structure
- Shared package or header holds:
  - the state encoding localparams (IDLE, PREP, CALC, FIX, OUT);
  - flag bit indices FLAG_OVERFLOW = 0 and FLAG_DIV0 = 1.
- Natural sub-module divide_core_iter: the shift/subtract datapath plus the iteration counter, with a start/done interface. axi_divide keeps the join, sign handling, special cases and the output register.

## Test plan
- Unsigned, WIDTH_N = WIDTH_D = 16: 100 / 7 → q = 14, r = 2, q_tuser = 0; q_tvalid exactly 18 cycles after the accept.
- Signed:
  - −7 / 2 → q = −3, r = −1.
  - 7 / −2 → q = −3, r = 1.
  - −32768 / −1 → q = 32767, r = 0, q_tuser = 01.
- Divide by zero:
  - signed 500 / 0 → q = 32767, r = 0, q_tuser = 10.
  - unsigned 500 / 0 → q = 0xFFFF.
- Join and back-pressure:
  - n_tvalid alone for 10 cycles → neither stream is consumed.
  - q_tready low for 20 cycles → output held stable, no new accept; the next accept comes 1 cycle after the OUT handshake.
- clear asserted in CALC and async reset asserted in OUT → no output beat; all outputs equal their reset values; the next operation completes correctly.
- Random regression: 10k random operand pairs with random valid/ready throttling on all three ports → every result matches the C-semantics model and the tlast order is preserved.
